hidden_forward: RTL and testbench

HIDDEN_FORWARD -- requirements
Module: hidden_forward

---
 rtl/hidden_pkg.sv | 8 +
 rtl/sat_relu.sv | 10 +
 rtl/hidden_forward.sv | 81 ++++++++
 tb/tb_hidden_forward.sv | 138 +++++++++++++
 4 files changed

// File: rtl/hidden_pkg.sv
// hidden_pkg: shared sizes, FSM states and activation limit for the hidden-layer neuron.
package hidden_pkg;
    localparam int N_IN     = 4;
    localparam int W_W      = 8;
    localparam int ACC_W    = 11;
    localparam int RELU_MAX = 127;
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/sat_relu.sv
// sat_relu: ReLU of a signed sum, saturated to 0..RELU_MAX.
module sat_relu import hidden_pkg::*; #(
    parameter int IN_W = ACC_W
) (
    input  logic signed [IN_W-1:0] sum,
    output logic [7:0]             relu
);
    localparam logic signed [IN_W-1:0] MAX = IN_W'(RELU_MAX);
    assign relu = sum[IN_W-1] ? 8'd0 : (sum > MAX) ? 8'(RELU_MAX) : sum[7:0];
endmodule

// File: rtl/hidden_forward.sv
// hidden_forward: serial binary-input neuron, one weight per cycle, step and ReLU outputs.
module hidden_forward #(
    parameter int N_IN  = hidden_pkg::N_IN,
    parameter int W_W   = hidden_pkg::W_W,
    parameter int ACC_W = hidden_pkg::ACC_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [N_IN-1:0]         x_i,
    input  logic signed [W_W-1:0]   w0_i,
    input  logic signed [W_W-1:0]   w1_i,
    input  logic signed [W_W-1:0]   w2_i,
    input  logic signed [W_W-1:0]   w3_i,
    input  logic signed [W_W-1:0]   bias_i,
    output logic                    busy_o,
    output logic                    valid_o,
    output logic                    y_o,
    output logic signed [ACC_W-1:0] sum_o,
    output logic [7:0]              relu_o,
    output logic [N_IN-1:0]         x_o
);
    import hidden_pkg::*;
    localparam int K_W = $clog2(N_IN);

    state_t                  state;
    logic [K_W-1:0]          k;
    logic [N_IN-1:0]         x_q, x_r;
    logic signed [W_W-1:0]   w_q [N_IN];
    logic signed [ACC_W-1:0] acc, sum_r;
    logic                    y_r, fire;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            k     <= '0;
            acc   <= '0;
            x_q   <= '0;
            w_q   <= '{default: '0};
            sum_r <= '0;
            y_r   <= 1'b0;
            x_r   <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    x_q   <= x_i;
                    w_q   <= '{w0_i, w1_i, w2_i, w3_i};
                    acc   <= ACC_W'(bias_i);
                    k     <= '0;
                    state <= ACC;
                end
                ACC: if (abort_i) state <= IDLE;
                else begin
                    if (x_q[k]) acc <= acc + ACC_W'(w_q[k]);
                    k <= k + K_W'(1);
                    if (k == K_W'(N_IN - 1)) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    if (!abort_i) begin
                        sum_r <= acc;
                        y_r   <= ~acc[ACC_W-1];
                        x_r   <= x_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The DONE cycle presents the fresh result directly; an abort in that cycle suppresses it.
    assign fire    = (state == DONE) && !abort_i;
    assign valid_o = fire;
    assign busy_o  = state != IDLE;
    assign sum_o   = fire ? acc : sum_r;
    assign y_o     = fire ? ~acc[ACC_W-1] : y_r;
    assign x_o     = fire ? x_q : x_r;

    sat_relu #(.IN_W(ACC_W)) u_sat (.sum(sum_o), .relu(relu_o));
endmodule

// File: tb/tb_hidden_forward.sv
// tb_hidden_forward: scoreboarded random and directed checks of hidden_forward against an arithmetic model.
module tb_hidden_forward;
    logic clk = 1'b0, rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0;
    logic [3:0] x_i = '0;
    logic [7:0] w0_i = '0, w1_i = '0, w2_i = '0, w3_i = '0, bias_i = '0;
    logic busy_o, valid_o, y_o;
    logic [10:0] sum_o;
    logic [7:0] relu_o;
    logic [3:0] x_o;

    typedef struct {int vcyc; int sum; int y; int relu; int x;} exp_t;
    exp_t q[$];
    exp_t last = '{0, 0, 0, 0, 0};
    int cyc = 0, acc_cyc = -1, busy_end = -1;
    int compared = 0, mismatched = 0;

    hidden_forward dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i), .x_i(x_i),
        .w0_i(w0_i), .w1_i(w1_i), .w2_i(w2_i), .w3_i(w3_i), .bias_i(bias_i),
        .busy_o(busy_o), .valid_o(valid_o), .y_o(y_o), .sum_o(sum_o), .relu_o(relu_o), .x_o(x_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string n, int act, int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", n, cyc, act, exp);
        end
    endfunction

    function automatic exp_t model(int c, logic [3:0] x, logic [7:0] w0, w1, w2, w3, b);
        int w[4];
        exp_t e;
        w = '{int'($signed(w0)), int'($signed(w1)), int'($signed(w2)), int'($signed(w3))};
        e.sum = int'($signed(b));
        for (int i = 0; i < 4; i++) if (x[i]) e.sum += w[i];
        e.vcyc = c + 5;
        e.y    = e.sum >= 0 ? 1 : 0;
        e.relu = e.sum < 0 ? 0 : (e.sum > 127 ? 127 : e.sum);
        e.x    = int'(x);
        return e;
    endfunction

    task automatic step(input logic s, a, r, input logic [3:0] x, input logic [7:0] w0, w1, w2, w3, b);
        int c;
        @(posedge clk);
        #1;
        start_i = s; abort_i = a; rst_i = r; x_i = x;
        w0_i = w0; w1_i = w1; w2_i = w2; w3_i = w3; bias_i = b;
        c = cyc;
        if (r) begin
            q.delete();
            busy_end = -1;
            #1;
            chk("rst_busy", int'(busy_o), 0);
            chk("rst_valid", int'(valid_o), 0);
            chk("rst_sum", int'($signed(sum_o)), 0);
            chk("rst_y", int'(y_o), 0);
            chk("rst_relu", int'(relu_o), 0);
            chk("rst_x", int'(x_o), 0);
        end else if (a && c > acc_cyc && c <= busy_end) begin
            q.delete();
            busy_end = c;
        end else if (s && c > busy_end) begin
            q.push_back(model(c, x, w0, w1, w2, w3, b));
            acc_cyc  = c;
            busy_end = c + 5;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 4'($urandom), 8'($urandom), 8'($urandom),
                        8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_i) last = '{0, 0, 0, 0, 0};
        chk("busy", int'(busy_o), (!rst_i && cyc > acc_cyc && cyc <= busy_end) ? 1 : 0);
        if (valid_o) begin
            if (q.size() == 0) chk("spurious_valid", 1, 0);
            else begin
                e = q.pop_front();
                chk("latency", cyc, e.vcyc);
                chk("sum", int'($signed(sum_o)), e.sum);
                chk("y", int'(y_o), e.y);
                chk("relu", int'(relu_o), e.relu);
                chk("x", int'(x_o), e.x);
                last = e;
            end
        end else begin
            if (q.size() != 0 && q[0].vcyc <= cyc) begin
                chk("missing_valid", 0, 1);
                void'(q.pop_front());
            end
            chk("hold_sum", int'($signed(sum_o)), last.sum);
            chk("hold_y", int'(y_o), last.y);
            chk("hold_relu", int'(relu_o), last.relu);
            chk("hold_x", int'(x_o), last.x);
        end
    end

    initial begin
        step(1'b0, 1'b0, 1'b1, 4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, -8'sd5);
        idle(7);
        step(1'b1, 1'b0, 1'b0, 4'b0101, -8'sd100, 8'd127, -8'sd100, 8'd127, -8'sd128);
        idle(7);
        step(1'b1, 1'b0, 1'b0, 4'b1111, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127);
        idle(7);
        step(1'b1, 1'b0, 1'b0, 4'b1111, -8'sd128, -8'sd128, -8'sd128, -8'sd128, -8'sd128);
        idle(7);
        repeat (10) step(1'b1, 1'b0, 1'b0, 4'b0000, 8'($urandom), 8'($urandom), 8'($urandom),
                         8'($urandom), 8'd0);
        idle(7);
        step(1'b1, 1'b0, 1'b0, 4'b1011, 8'd50, 8'd60, 8'd70, 8'd80, 8'd1);
        idle(1);
        step(1'b0, 1'b1, 1'b0, 4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        idle(7);
        step(1'b1, 1'b0, 1'b0, 4'b0110, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 4'b1001, 8'd3, 8'd4, 8'd5, 8'd6, -8'sd2);
        idle(7);
        repeat (1500) step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                           $urandom_range(0, 199) == 0, 4'($urandom), 8'($urandom), 8'($urandom),
                           8'($urandom), 8'($urandom), 8'($urandom));
        idle(8);
        chk("drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
